// File: rtl/circuit_amp_array.sv
// circuit_amp_array: N-channel fixed-point amplifier with optional low-pass, one shared multiplier swept one channel per cycle.
module circuit_amp_array #(
   parameter int N_CH       = 4,
   parameter int WIDTH      = 16,
   parameter int GAIN_W     = 16,
   parameter int GAIN_FRAC  = 8,
   parameter int FILT_SHIFT = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [N_CH*WIDTH-1:0]    v_in,
   input  logic [N_CH*GAIN_W-1:0]   gain,
   output logic [N_CH*WIDTH-1:0]    v_out,
   output logic                     busy,
   output logic                     done,
   output logic [N_CH-1:0]          sat_flags
);
   localparam int PW = WIDTH + GAIN_W;
   localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [CW-1:0] ch_idx;
   logic [N_CH*WIDTH-1:0] in_snap;
   logic [N_CH*GAIN_W-1:0] gain_snap;
   logic accept, last, clamp_hi, clamp_lo;
   logic signed [WIDTH-1:0] x, y, t_sat, y_nx;
   logic signed [GAIN_W-1:0] g;
   logic signed [PW-1:0] t;
   logic signed [WIDTH:0] d;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      accept = state == IDLE && start;
      last = int'(ch_idx) == N_CH - 1;
      state_nx = accept ? RUN : (state == RUN && last) ? IDLE : state;
   end

   assign busy = state == RUN;

   // The filter state is the channel's output register itself.
   always_comb begin
      x = in_snap[int'(ch_idx)*WIDTH +: WIDTH];
      g = gain_snap[int'(ch_idx)*GAIN_W +: GAIN_W];
      y = v_out[int'(ch_idx)*WIDTH +: WIDTH];
      t = (PW'(x) * PW'(g)) >>> GAIN_FRAC;
      clamp_hi = !t[PW-1] && |t[PW-2:WIDTH-1];
      clamp_lo = t[PW-1] && !(&t[PW-2:WIDTH-1]);
      t_sat = clamp_hi ? {1'b0, {(WIDTH-1){1'b1}}} : clamp_lo ? {1'b1, {(WIDTH-1){1'b0}}} : t[WIDTH-1:0];
      d = $signed({t_sat[WIDTH-1], t_sat}) - $signed({y[WIDTH-1], y});
      y_nx = FILT_SHIFT == 0 ? t_sat : WIDTH'($signed({y[WIDTH-1], y}) + (d >>> FILT_SHIFT));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ch_idx    <= '0;
         in_snap   <= '0;
         gain_snap <= '0;
         v_out     <= '0;
         sat_flags <= '0;
         done      <= 1'b0;
      end else begin
         done <= state == RUN && last;
         if (accept) begin
            in_snap   <= v_in;
            gain_snap <= gain;
            ch_idx    <= '0;
            sat_flags <= '0;
         end else if (state == RUN) begin
            v_out[int'(ch_idx)*WIDTH +: WIDTH] <= y_nx;
            sat_flags[ch_idx] <= sat_flags[ch_idx] | clamp_hi | clamp_lo;
            ch_idx <= last ? '0 : ch_idx + 1'b1;
         end
      end
endmodule

// File: tb/tb_circuit_amp_array.sv
// tb_circuit_amp_array: directed checks of a plain (K=0) and a filtered (K=2) amplifier array.
module tb_circuit_amp_array;
   logic clk = 0, rst_n = 0, start = 0, start_f = 0;
   logic [63:0] v_in = '0, gain = '0, v_out, v_in_f = '0, gain_f = '0, v_out_f;
   logic busy, done, busy_f, done_f;
   logic [3:0] sat_flags, sat_flags_f;
   int total = 0, bad = 0;

   circuit_amp_array dut (.clk(clk), .rst_n(rst_n), .start(start), .v_in(v_in), .gain(gain),
      .v_out(v_out), .busy(busy), .done(done), .sat_flags(sat_flags));
   circuit_amp_array #(.FILT_SHIFT(2)) dut_f (.clk(clk), .rst_n(rst_n), .start(start_f), .v_in(v_in_f),
      .gain(gain_f), .v_out(v_out_f), .busy(busy_f), .done(done_f), .sat_flags(sat_flags_f));

   always #5 clk = ~clk;

   function automatic logic [63:0] pk(int a, int b, int c, int e);
      return {16'(e), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic sweep(input bit f);
      if (f) start_f = 1; else start = 1;
      tick;
      start = 0;
      start_f = 0;
      repeat (4) tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) tick;
      chk("rst_vout", v_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sat", sat_flags, 0);
      rst_n = 1;
      tick;
      // passthrough x2, edge by edge
      gain = {4{16'h0200}};
      v_in = pk(1000, -1000, 0, 7);
      start = 1;
      tick;
      start = 0;
      chk("e0_busy", busy, 1);
      chk("e0_vout", v_out, 0);
      tick;
      chk("e1_vout", v_out, pk(2000, 0, 0, 0));
      chk("e1_done", done, 0);
      tick;
      chk("e2_vout", v_out, pk(2000, -2000, 0, 0));
      tick;
      chk("e3_vout", v_out, pk(2000, -2000, 0, 0));
      chk("e3_busy", busy, 1);
      tick;
      chk("e4_vout", v_out, pk(2000, -2000, 0, 14));
      chk("e4_done", done, 1);
      chk("e4_busy", busy, 0);
      chk("e4_sat", sat_flags, 0);
      tick;
      chk("e5_done", done, 0);
      // saturation and flag clearing
      v_in = pk(20000, -20000, 0, 0);
      sweep(0);
      chk("sat_vout", v_out, pk(32767, -32768, 0, 0));
      chk("sat_flags", sat_flags, 4'b0011);
      v_in = pk(100, 0, 0, 0);
      start = 1;
      tick;
      start = 0;
      chk("sat_clear", sat_flags, 0);
      repeat (4) tick;
      chk("sat_next", v_out, pk(200, 0, 0, 0));
      chk("sat_next_flags", sat_flags, 0);
      // floor rounding toward -inf
      gain = {4{16'h0080}};
      v_in = pk(-3, 3, 0, 0);
      sweep(0);
      chk("floor", v_out, pk(-2, 1, 0, 0));
      // start held high: back-to-back sweeps, mid-sweep input change
      gain = {4{16'h0100}};
      v_in = pk(1, 2, 3, 4);
      start = 1;
      repeat (5) tick;
      chk("hold_done1", done, 1);
      tick;
      chk("hold_acc_busy", busy, 1);
      chk("hold_acc_done", done, 0);
      repeat (2) tick;
      v_in = pk(9, 9, 9, 9);
      repeat (2) tick;
      chk("hold_done2", done, 1);
      chk("snap_hold", v_out, pk(1, 2, 3, 4));
      tick;
      start = 0;
      repeat (2) tick;
      start = 1;
      tick;
      start = 0;
      tick;
      chk("hold_done3", done, 1);
      chk("new_snap", v_out, pk(9, 9, 9, 9));
      tick;
      chk("no_queue_busy", busy, 0);
      chk("no_queue_done", done, 0);
      // first-order low-pass, K=2: floor(-577/4) = -145 on the decay step
      gain_f = {4{16'h0100}};
      v_in_f = pk(1000, 1000, 1000, 1000);
      sweep(1);
      chk("filt1", v_out_f, pk(250, 250, 250, 250));
      chk("filt1_done", done_f, 1);
      sweep(1);
      chk("filt2", v_out_f, pk(437, 437, 437, 437));
      sweep(1);
      chk("filt3", v_out_f, pk(577, 577, 577, 577));
      v_in_f = 0;
      sweep(1);
      chk("filt4", v_out_f, pk(432, 432, 432, 432));
      // reset mid-sweep
      gain = {4{16'h0200}};
      v_in = pk(1000, 1000, 1000, 1000);
      v_in_f = pk(1000, 1000, 1000, 1000);
      start = 1;
      start_f = 1;
      tick;
      start = 0;
      start_f = 0;
      repeat (2) tick;
      #2 rst_n = 0;
      #1;
      chk("arst_vout", v_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_vout_f", v_out_f, 0);
      tick;
      rst_n = 1;
      repeat (3) tick;
      chk("arst_no_done", done, 0);
      chk("arst_idle", busy, 0);
      start = 1;
      start_f = 1;
      tick;
      start = 0;
      start_f = 0;
      repeat (4) tick;
      chk("post_rst", v_out, pk(2000, 2000, 2000, 2000));
      chk("post_rst_done", done, 1);
      chk("post_rst_filt", v_out_f, pk(250, 250, 250, 250));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
